sync_fifo: RTL and testbench

//  Single-clock synchronous FIFO buffering DATA_WIDTH-bit words between a producer and a consumer in one clock domain.

---
 rtl/fifo_pkg.sv | 21 ++
 rtl/fifo_ram.sv | 39 +++
 rtl/sync_fifo.sv | 118 +++++++++++
 tb/tb_sync_fifo.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared sizing helpers for the synchronous FIFO: pointer width and the
// perc_full occupancy threshold.
package fifo_pkg;

   // Ceiling log2 with a floor of 1 so a pointer is never zero bits wide.
   function automatic int clog2(input int value);
      int w;
      w = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            w = i + 1;
         end
      end
      return (w < 1) ? 1 : w;
   endfunction

   function automatic int perc_threshold(input int depth, input int perc);
      return (depth * perc) / 100;
   endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write, registered read with read enable.
// The read register resets to zero; the array itself is never cleared.
module fifo_ram
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 16,
   parameter int AW         = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [AW-1:0]         wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [AW-1:0]         rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] rd_data_q;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_data_q <= '0;
      end else if (rd_en) begin
         rd_data_q <= mem[rd_addr];
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered (non-show-ahead) read data and occupancy flags.
// Define FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module sync_fifo
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 16,
   parameter int ADDR_BITS  = 10,
   parameter int PERC_FULL  = 75
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  wrreq,
   input  logic                  rdreq,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  perc_full,
   output logic                  full,
   output logic                  empty,
   output logic [ADDR_BITS-1:0]  usedw
`ifdef FIFO_ERR_FLAGS_EN
   ,
   output logic                  overflow,
   output logic                  underflow
`endif
);

   localparam int PTR_W  = clog2(FIFO_DEPTH);
   localparam int THRESH = perc_threshold(FIFO_DEPTH, PERC_FULL);

   localparam logic [PTR_W-1:0]     LAST_PTR   = PTR_W'(FIFO_DEPTH - 1);
   localparam logic [ADDR_BITS-1:0] DEPTH_CNT  = ADDR_BITS'(FIFO_DEPTH);
   localparam logic [ADDR_BITS-1:0] THRESH_CNT = ADDR_BITS'(THRESH);

   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [ADDR_BITS-1:0] usedw_q, usedw_d;
   logic                 wr_ok, rd_ok;

   // Flags come from the registered count, so an access shows up one cycle later.
   assign full      = (usedw_q == DEPTH_CNT);
   assign empty     = (usedw_q == '0);
   assign perc_full = (usedw_q >= THRESH_CNT);
   assign usedw     = usedw_q;

   assign wr_ok = en & wrreq & ~full;
   assign rd_ok = en & rdreq & ~empty;

   // Explicit wrap compare keeps non-power-of-two depths correct.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      usedw_d  = usedw_q;
      if (wr_ok) begin
         wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (rd_ok) begin
         rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      case ({wr_ok, rd_ok})
         2'b10:   usedw_d = usedw_q + ADDR_BITS'(1);
         2'b01:   usedw_d = usedw_q - ADDR_BITS'(1);
         default: usedw_d = usedw_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         usedw_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         usedw_q  <= usedw_d;
      end
   end

`ifdef FIFO_ERR_FLAGS_EN
   logic overflow_q, overflow_d;
   logic underflow_q, underflow_d;

   always_comb begin
      overflow_d  = overflow_q  | (en & wrreq & full);
      underflow_d = underflow_q | (en & rdreq & empty);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign overflow  = overflow_q;
   assign underflow = underflow_q;
`endif

   fifo_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (FIFO_DEPTH),
      .AW         (PTR_W)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_ok),
      .wr_addr (wr_ptr_q),
      .wr_data (data_in),
      .rd_en   (rd_ok),
      .rd_addr (rd_ptr_q),
      .rd_data (data_out)
   );

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo (default 32 x 16, threshold 12).
module tb_sync_fifo;

   logic        clk;
   logic        rst;
   logic        en;
   logic        wrreq;
   logic        rdreq;
   logic [31:0] data_in;
   logic [31:0] data_out;
   logic        perc_full;
   logic        full;
   logic        empty;
   logic [9:0]  usedw;
`ifdef FIFO_ERR_FLAGS_EN
   logic        overflow;
   logic        underflow;
`endif

   int pass_cnt  = 0;
   int total_cnt = 0;

   sync_fifo dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .wrreq     (wrreq),
      .rdreq     (rdreq),
      .data_in   (data_in),
      .data_out  (data_out),
      .perc_full (perc_full),
      .full      (full),
      .empty     (empty),
      .usedw     (usedw)
`ifdef FIFO_ERR_FLAGS_EN
      ,
      .overflow  (overflow),
      .underflow (underflow)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change on the falling edge; outputs are sampled on the next falling edge.
   task automatic cyc(input logic w, input logic r, input logic [31:0] d);
      wrreq   = w;
      rdreq   = r;
      data_in = d;
      @(negedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b0; en = 1'b1; wrreq = 1'b0; rdreq = 1'b0; data_in = '0;
      #3;
      total_cnt++;
      if ({usedw, empty, full, perc_full, data_out} !== {10'd0, 1'b1, 1'b0, 1'b0, 32'd0})
         $display("FAIL reset_init: usedw=%0d empty=%b full=%b perc=%b dout=%h, want 0 1 0 0 0",
                  usedw, empty, full, perc_full, data_out);
      else pass_cnt++;
      @(negedge clk);
      rst = 1'b1;
      cyc(1'b1, 1'b0, 32'h1234);
      cyc(1'b1, 1'b0, 32'h5678);
      cyc(1'b0, 1'b1, 32'h0);
      total_cnt++;
      if (data_out !== 32'h1234 || usedw !== 10'd1)
         $display("FAIL pre_reset_read: dout=%h usedw=%0d, want 1234 1", data_out, usedw);
      else pass_cnt++;
      #2 rst = 1'b0;
      #1;
      total_cnt++;
      if ({usedw, empty, full, perc_full, data_out} !== {10'd0, 1'b1, 1'b0, 1'b0, 32'd0})
         $display("FAIL async_reset: usedw=%0d empty=%b full=%b perc=%b dout=%h, want 0 1 0 0 0",
                  usedw, empty, full, perc_full, data_out);
      else pass_cnt++;
      @(negedge clk);
      rst = 1'b1;
      cyc(1'b0, 1'b0, 32'h0);
      total_cnt++;
      if (usedw !== 10'd0 || empty !== 1'b1)
         $display("FAIL reset_discard: usedw=%0d empty=%b, want 0 1", usedw, empty);
      else pass_cnt++;
   endtask

   task automatic test_basic;
      cyc(1'b1, 1'b0, 32'h1555);
      cyc(1'b1, 1'b0, 32'h0AAA);
      cyc(1'b0, 1'b0, 32'h0);
      total_cnt++;
      if (usedw !== 10'd2 || data_out !== 32'd0)
         $display("FAIL basic_written: usedw=%0d dout=%h, want 2 0", usedw, data_out);
      else pass_cnt++;
      cyc(1'b0, 1'b1, 32'h0);
      total_cnt++;
      if (data_out !== 32'h1555 || usedw !== 10'd1)
         $display("FAIL basic_read1: dout=%h usedw=%0d, want 1555 1", data_out, usedw);
      else pass_cnt++;
      cyc(1'b0, 1'b1, 32'h0);
      total_cnt++;
      if (data_out !== 32'h0AAA || empty !== 1'b1 || usedw !== 10'd0)
         $display("FAIL basic_read2: dout=%h empty=%b usedw=%0d, want aaa 1 0", data_out, empty, usedw);
      else pass_cnt++;
      cyc(1'b0, 1'b1, 32'h0);
      total_cnt++;
      if (data_out !== 32'h0AAA || usedw !== 10'd0)
         $display("FAIL read_empty_hold: dout=%h usedw=%0d, want aaa 0", data_out, usedw);
      else pass_cnt++;
   endtask

   task automatic test_fill;
      for (int i = 0; i < 16; i++) begin
         cyc(1'b1, 1'b0, i);
         total_cnt++;
         if (usedw !== 10'(i + 1) || perc_full !== (i + 1 >= 12) || full !== (i == 15))
            $display("FAIL fill_%0d: usedw=%0d perc=%b full=%b, want %0d %b %b",
                     i, usedw, perc_full, full, i + 1, (i + 1 >= 12), (i == 15));
         else pass_cnt++;
      end
      cyc(1'b1, 1'b0, 32'hDEAD);
      total_cnt++;
      if (usedw !== 10'd16 || full !== 1'b1)
         $display("FAIL fill_overwrite: usedw=%0d full=%b, want 16 1", usedw, full);
      else pass_cnt++;
      for (int i = 0; i < 16; i++) begin
         cyc(1'b0, 1'b1, 32'h0);
         total_cnt++;
         if (data_out !== 32'(i) || usedw !== 10'(15 - i))
            $display("FAIL drain_%0d: dout=%h usedw=%0d, want %h %0d", i, data_out, usedw, i, 15 - i);
         else pass_cnt++;
      end
      total_cnt++;
      if (empty !== 1'b1 || perc_full !== 1'b0 || full !== 1'b0)
         $display("FAIL drain_flags: empty=%b perc=%b full=%b, want 1 0 0", empty, perc_full, full);
      else pass_cnt++;
   endtask

   task automatic test_enable;
      cyc(1'b1, 1'b0, 32'h11);
      cyc(1'b1, 1'b0, 32'h22);
      cyc(1'b0, 1'b1, 32'h0);
      en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cyc(i[0], ~i[0] | i[1], 32'h99);
         total_cnt++;
         if (usedw !== 10'd1 || data_out !== 32'h11 || empty !== 1'b0 || full !== 1'b0)
            $display("FAIL en_hold_%0d: usedw=%0d dout=%h empty=%b full=%b, want 1 11 0 0",
                     i, usedw, data_out, empty, full);
         else pass_cnt++;
      end
      en = 1'b1;
      cyc(1'b0, 1'b1, 32'h0);
      total_cnt++;
      if (data_out !== 32'h22 || empty !== 1'b1)
         $display("FAIL en_resume: dout=%h empty=%b, want 22 1", data_out, empty);
      else pass_cnt++;
   endtask

   task automatic test_wrap;
      for (int k = 0; k < 5; k++) cyc(1'b1, 1'b0, 32'hC000 + k * 3);
      total_cnt++;
      if (usedw !== 10'd5)
         $display("FAIL wrap_prefill: usedw=%0d, want 5", usedw);
      else pass_cnt++;
      for (int k = 0; k < 30; k++) begin
         cyc(1'b1, 1'b1, 32'hC000 + (k + 5) * 3);
         total_cnt++;
         if (data_out !== 32'hC000 + k * 3 || usedw !== 10'd5)
            $display("FAIL wrap_both_%0d: dout=%h usedw=%0d, want %h 5",
                     k, data_out, usedw, 32'hC000 + k * 3);
         else pass_cnt++;
      end
      for (int k = 30; k < 35; k++) begin
         cyc(1'b0, 1'b1, 32'h0);
         total_cnt++;
         if (data_out !== 32'hC000 + k * 3 || usedw !== 10'(34 - k))
            $display("FAIL wrap_drain_%0d: dout=%h usedw=%0d, want %h %0d",
                     k, data_out, usedw, 32'hC000 + k * 3, 34 - k);
         else pass_cnt++;
      end
      total_cnt++;
      if (empty !== 1'b1)
         $display("FAIL wrap_empty: empty=%b, want 1", empty);
      else pass_cnt++;
   endtask

   task automatic test_empty_both;
      cyc(1'b1, 1'b1, 32'h7777);
      total_cnt++;
      if (usedw !== 10'd1 || empty !== 1'b0 || data_out !== 32'hC000 + 34 * 3)
         $display("FAIL empty_wr_rd: usedw=%0d empty=%b dout=%h, want 1 0 %h",
                  usedw, empty, data_out, 32'hC000 + 34 * 3);
      else pass_cnt++;
      cyc(1'b0, 1'b1, 32'h0);
      total_cnt++;
      if (data_out !== 32'h7777 || empty !== 1'b1)
         $display("FAIL empty_wr_rd_read: dout=%h empty=%b, want 7777 1", data_out, empty);
      else pass_cnt++;
   endtask

   task automatic test_full_both;
      for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 32'hF00 + i);
      cyc(1'b1, 1'b1, 32'hBAD);
      total_cnt++;
      if (data_out !== 32'hF00 || usedw !== 10'd15 || full !== 1'b0)
         $display("FAIL full_wr_rd: dout=%h usedw=%0d full=%b, want f00 15 0", data_out, usedw, full);
      else pass_cnt++;
      for (int i = 1; i < 16; i++) cyc(1'b0, 1'b1, 32'h0);
      total_cnt++;
      if (data_out !== 32'hF0F || empty !== 1'b1)
         $display("FAIL full_wr_rd_drain: dout=%h empty=%b, want f0f 1", data_out, empty);
      else pass_cnt++;
   endtask

`ifdef FIFO_ERR_FLAGS_EN
   task automatic test_err_flags;
      @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      total_cnt++;
      if (overflow !== 1'b0 || underflow !== 1'b0)
         $display("FAIL err_reset: ovf=%b unf=%b, want 0 0", overflow, underflow);
      else pass_cnt++;
      en = 1'b0;
      cyc(1'b0, 1'b1, 32'h0);
      en = 1'b1;
      total_cnt++;
      if (underflow !== 1'b0)
         $display("FAIL err_en_gate: unf=%b, want 0", underflow);
      else pass_cnt++;
      cyc(1'b0, 1'b1, 32'h0);
      total_cnt++;
      if (underflow !== 1'b1 || overflow !== 1'b0)
         $display("FAIL err_underflow: ovf=%b unf=%b, want 0 1", overflow, underflow);
      else pass_cnt++;
      for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, i);
      total_cnt++;
      if (overflow !== 1'b0)
         $display("FAIL err_no_ovf_yet: ovf=%b, want 0", overflow);
      else pass_cnt++;
      cyc(1'b1, 1'b0, 32'h55);
      total_cnt++;
      if (overflow !== 1'b1)
         $display("FAIL err_overflow: ovf=%b, want 1", overflow);
      else pass_cnt++;
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 32'h0);
      total_cnt++;
      if (overflow !== 1'b1 || underflow !== 1'b1)
         $display("FAIL err_sticky: ovf=%b unf=%b, want 1 1", overflow, underflow);
      else pass_cnt++;
      #2 rst = 1'b0;
      #1;
      total_cnt++;
      if (overflow !== 1'b0 || underflow !== 1'b0)
         $display("FAIL err_clear: ovf=%b unf=%b, want 0 0", overflow, underflow);
      else pass_cnt++;
      @(negedge clk);
      rst = 1'b1;
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_fill();
      test_enable();
      test_wrap();
      test_empty_both();
      test_full_both();
`ifdef FIFO_ERR_FLAGS_EN
      test_err_flags();
`endif
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
